// File: rtl/jaxis_video_master.sv
// Raster pixel interface to AXI4-Stream video master (tuser = SOF, tlast = EOL).
// A one-pixel holdback register lets the last pixel of a line carry tlast; a small FIFO absorbs backpressure.
module jaxis_video_master #(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          pixel_clock,
   input  logic                          pixel_reset_n,
   input  logic                          frame_valid,
   input  logic                          line_valid,
   input  logic [3*DW-1:0]               rgb24,
   input  logic                          rgb24_valid,
   output logic [3*DW-1:0]               m_axis_video_tdata,
   output logic                          m_axis_video_tvalid,
   input  logic                          m_axis_video_tready,
   output logic                          m_axis_video_tuser,
   output logic                          m_axis_video_tlast,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_ALMOST = LW'(FIFO_DEPTH - 1);

   typedef enum logic {
      WAIT_SOF,
      ACTIVE
   } state_t;

   typedef struct packed {
      logic            user;
      logic            last;
      logic [3*DW-1:0] pix;
   } entry_t;

   state_t          state_q, state_d;
   logic            fv_d1_q, fv_d1_d;
   logic            lv_d1_q, lv_d1_d;
   logic            sof_pending_q, sof_pending_d;
   logic            h_valid_q, h_valid_d;
   logic            h_sof_q, h_sof_d;
   logic [3*DW-1:0] h_pix_q, h_pix_d;
   logic            overflow_q, overflow_d;
   logic [LW-1:0]   level_q, level_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

   entry_t          mem [FIFO_DEPTH];
   entry_t          head;
   entry_t          push_entry;
   entry_t          wr_entry;
   logic            push_req;
   logic            wr_en;
   logic            ovf_set;
   logic            accept;
   logic            fv_rise;
   logic            line_end;
   logic            tvalid;
   logic            pop;

   assign accept   = frame_valid & line_valid & rgb24_valid;
   assign fv_rise  = frame_valid & ~fv_d1_q;
   // A simultaneous line_valid and frame_valid fall collapses into one line end.
   assign line_end = (lv_d1_q & ~line_valid) | (fv_d1_q & ~frame_valid);
   assign tvalid   = (level_q != '0);
   assign pop      = tvalid & m_axis_video_tready;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      fv_d1_d       = frame_valid;
      lv_d1_d       = line_valid;
      sof_pending_d = sof_pending_q;
      h_valid_d     = h_valid_q;
      h_sof_d       = h_sof_q;
      h_pix_d       = h_pix_q;
      push_req      = 1'b0;
      push_entry    = '0;
      wr_en         = 1'b0;
      wr_entry      = '0;
      ovf_set       = 1'b0;

      case (state_q)
         WAIT_SOF: begin
            h_valid_d = 1'b0;
            if (fv_rise) begin
               state_d       = ACTIVE;
               sof_pending_d = 1'b1;
            end
         end
         ACTIVE: begin
            if (fv_rise) sof_pending_d = 1'b1;
            if (accept) begin
               push_req      = h_valid_q;
               push_entry    = '{user: h_sof_q, last: 1'b0, pix: h_pix_q};
               h_valid_d     = 1'b1;
               h_sof_d       = sof_pending_q | fv_rise;
               h_pix_d       = rgb24;
               sof_pending_d = 1'b0;
            end else if (line_end) begin
               push_req   = h_valid_q;
               push_entry = '{user: h_sof_q, last: 1'b1, pix: h_pix_q};
               h_valid_d  = 1'b0;
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      // Room is judged on the registered level; a same-cycle pop earns no credit.
      if (push_req) begin
         if (level_q == LVL_FULL) begin
            ovf_set = 1'b1;
         end else begin
            wr_en    = 1'b1;
            wr_entry = push_entry;
            if (!push_entry.last && level_q == LVL_ALMOST) begin
               wr_entry.last = 1'b1;
               ovf_set       = 1'b1;
            end
         end
      end

      if (ovf_set) begin
         state_d       = WAIT_SOF;
         h_valid_d     = 1'b0;
         sof_pending_d = 1'b0;
      end
   end

   always_comb begin
      overflow_d = ovf_set | (overflow_q & ~clear_overflow);
      wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      if (wr_en && !pop)      level_d = level_q + LW'(1);
      else if (!wr_en && pop) level_d = level_q - LW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge pixel_clock or negedge pixel_reset_n) begin
      if (!pixel_reset_n) begin
         state_q       <= WAIT_SOF;
         fv_d1_q       <= 1'b1;
         lv_d1_q       <= 1'b0;
         sof_pending_q <= 1'b0;
         h_valid_q     <= 1'b0;
         h_sof_q       <= 1'b0;
         h_pix_q       <= '0;
         overflow_q    <= 1'b0;
         level_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fv_d1_q       <= fv_d1_d;
         lv_d1_q       <= lv_d1_d;
         sof_pending_q <= sof_pending_d;
         h_valid_q     <= h_valid_d;
         h_sof_q       <= h_sof_d;
         h_pix_q       <= h_pix_d;
         overflow_q    <= overflow_d;
         level_q       <= level_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // NOTE: the storage array is not reset; the outputs are gated by tvalid, so stale contents never escape.
   always_ff @(posedge pixel_clock) begin
      if (wr_en) mem[wr_ptr_q] <= wr_entry;
   end

   assign head                = mem[rd_ptr_q];
   assign m_axis_video_tvalid = tvalid;
   assign m_axis_video_tdata  = tvalid ? head.pix  : '0;
   assign m_axis_video_tuser  = tvalid ? head.user : 1'b0;
   assign m_axis_video_tlast  = tvalid ? head.last : 1'b0;
   assign overflow            = overflow_q;
   assign fifo_level          = level_q;

endmodule

// File: doc/jaxis_video_master.md
# jaxis_video_master

Raster-to-AXI4-Stream video transmitter: converts a free-running, non-stallable pixel interface (frame_valid / line_valid / rgb24 / rgb24_valid) into an AXI4-Stream video master with tuser = start-of-frame and tlast = end-of-line. It is the transmit-side counterpart of the AXI-Stream video slave at the encoder input. It drives the encoder from pixel-interface sources such as the ISP test path and the sensor bridge. A small FIFO absorbs downstream backpressure. On overflow, lines are truncated cleanly and the rest of the frame is dropped, so the emitted stream is always well-formed.

## Interface
Parameters:
- DW, 8, bits per colour component
- FIFO_DEPTH, 16, entries of {tuser, tlast, pixel}; power of 2, ≥ 4

Ports:
- pixel_clock  in  1  sole clock
- pixel_reset_n  in  1  reset, asynchronous, active-low
- frame_valid  in  1  high for the duration of a frame
- line_valid  in  1  high for the duration of a line
- rgb24  in  3*DW  pixel {B,G,R}
- rgb24_valid  in  1  pixel qualifier; a pixel is accepted when frame_valid & line_valid & rgb24_valid
- m_axis_video_tdata  out  3*DW  pixel {B,G,R}
- m_axis_video_tvalid  out  1  beat valid
- m_axis_video_tready  in  1  downstream ready
- m_axis_video_tuser  out  1  first pixel of frame
- m_axis_video_tlast  out  1  last pixel of line
- overflow  out  1  sticky; set on any truncation or discard
- clear_overflow  in  1  synchronous clear of overflow
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- States: WAIT_SOF and ACTIVE.
  - Reset enters WAIT_SOF.
  - WAIT_SOF→ACTIVE on a frame_valid rising edge (frame_valid & ~fv_d1). fv_d1 resets to 1, so a frame already in progress at reset release is ignored.
  - ACTIVE→WAIT_SOF on overflow.
  - In WAIT_SOF, all pixels are ignored and the holdback register is cleared.
- Holdback register H = {valid, sof, pixel}. Each accepted pixel (in ACTIVE):
  - If H.valid, push H with tlast=0.
  - Load H with the new pixel. H.sof = sof_pending.
  - sof_pending is set by the frame_valid rising edge and cleared by the first accepted pixel.
- Line end is line_valid falling (lv_d1 & ~line_valid) or frame_valid falling, with both in the same cycle counting as one event.
  - At line end, if H.valid, push H with tlast=1 and clear H.valid.
  - Accept and line end cannot coincide.
- Push rules, evaluated on the registered fifo_level L; a same-cycle pop is not credited:
  - L == FIFO_DEPTH: discard the entry; set overflow; go to WAIT_SOF.
  - tlast=0 push with L == FIFO_DEPTH-1: push with tlast forced to 1 (line truncated); set overflow; go to WAIT_SOF.
  - Otherwise: push as is.
- Consequence: every line already started downstream is terminated by tlast, and no partial line is ever left open.
- Pop when tvalid & tready. FIFO is first-in first-out, no reordering.
- overflow:
  - Set by the rules above; cleared by clear_overflow.
  - Set wins over a simultaneous clear.
  - After overflow, the next frame is delivered normally once frame_valid rises again.

## Timing
- Reset values:
  - tvalid, tdata, tuser, tlast, overflow: 0
  - fifo_level: 0
  - H.valid: 0; sof_pending: 0; state WAIT_SOF
- An entry pushed in cycle p is presented on m_axis_* in cycle p+1 if the FIFO was empty.
- Pixel latency:
  - A non-last pixel accepted in cycle t is pushed when the next pixel is accepted (earliest t+1) and appears at t+2.
  - The last pixel of a line is pushed in the cycle line_valid is first sampled low and appears one cycle later.
- AXI rules:
  - tvalid never depends on tready.
  - While tvalid & ~tready, tdata/tuser/tlast are held stable.
  - tvalid deasserts only after a handshake with the FIFO empty.
- Throughput: 1 beat/cycle with simultaneous push and pop; fifo_level unchanged in that case.
- Asynchronous reset mid-frame clears the FIFO immediately. The stream restarts with tuser on the next full frame.

## Test plan
- 4×2 frame, FIFO_DEPTH=16, tready=1, pixels 0..7 → 8 beats in order; tuser on beat 0 only; tlast on beats 3 and 7; overflow=0.
- Same frame, tready=0 for the first 12 cycles of the frame → fifo_level peaks at 8; tdata stable while stalled; all 8 beats delivered intact after tready=1.
- FIFO_DEPTH=4, tready=0, one 8-pixel line → FIFO holds p0..p3 with tlast on p3, fifo_level=4, overflow=1; p4..p7 dropped. With tready=1, the next frame is delivered complete with tuser.
- Reset asserted mid-line, released with frame_valid high → all outputs 0; nothing emitted until frame_valid falls and rises; that frame starts with tuser=1.
- Single-pixel line with line_valid and frame_valid falling in the same cycle → exactly one beat, tuser=1, tlast=1.
- clear_overflow asserted in the same cycle as a truncation → overflow=1; clear_overflow alone in a later cycle → overflow=0 the next cycle.
